// File: rtl/sw_db_pair.sv
// sw_db_pair: two-channel switch debouncer feeding fsm_eg_mult_seg.
//
// Each raw switch passes through a 2-flop synchroniser and then a four-state
// debounce FSM. The FSM only lets the level flip after the synchronised input
// has held steady across TICKS ticks of a shared prescaler. One prescaler
// serves both channels, so switches pressed together flip on the same tick.
//
// Parameters:
//   N      prescaler width; one m_tick every 2^N clocks
//   TICKS  stable prescaler ticks needed before the level flips (2..15)
//
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous, active-high
//   sw_a    raw switch A (asynchronous, bouncy)
//   sw_b    raw switch B (asynchronous, bouncy)
//   a       debounced level of A, registered
//   b       debounced level of B, registered
//   a_rise  one-cycle pulse on the first cycle of a = 1
//   b_rise  one-cycle pulse on the first cycle of b = 1

// sw_db_chan: synchroniser plus debounce FSM for one switch.
//
// Ports:
//   clk     system clock
//   reset   synchronous, active-high
//   sw      raw switch input
//   m_tick  shared prescaler tick, one cycle wide
//   level   debounced level, registered
//   rise    one-cycle pulse when level goes 0 -> 1, registered
//
// state | meaning
// ------+-----------------------------------------------------------
// ZERO  | level is 0, input agrees
// WAIT1 | level is 0, input has gone to 1, counting ticks to flip
// ONE   | level is 1, input agrees
// WAIT0 | level is 1, input has gone to 0, counting ticks to flip
module sw_db_chan #(
    parameter int TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    input  logic m_tick,
    output logic level,
    output logic rise
);

    localparam logic [1:0] ZERO  = 2'd0;
    localparam logic [1:0] WAIT1 = 2'd1;
    localparam logic [1:0] ONE   = 2'd2;
    localparam logic [1:0] WAIT0 = 2'd3;

    localparam logic [3:0] CNT_LAST = 4'(TICKS - 1);

    logic       s1;
    logic       s2;
    logic [1:0] state;
    logic [1:0] state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ZERO: begin
                if (s2) begin
                    state_next = WAIT1;
                    cnt_next   = 4'd0;
                end
            end
            WAIT1: begin
                // A return to 0 outranks a tick in the same cycle.
                if (!s2) begin
                    state_next = ZERO;
                end else if (m_tick) begin
                    if (cnt == CNT_LAST) begin
                        state_next = ONE;
                    end else begin
                        cnt_next = cnt + 4'd1;
                    end
                end
            end
            ONE: begin
                if (!s2) begin
                    state_next = WAIT0;
                    cnt_next   = 4'd0;
                end
            end
            WAIT0: begin
                // A return to 1 outranks a tick in the same cycle.
                if (s2) begin
                    state_next = ONE;
                end else if (m_tick) begin
                    if (cnt == CNT_LAST) begin
                        state_next = ZERO;
                    end else begin
                        cnt_next = cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_next = ZERO;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= ZERO;
            cnt   <= 4'd0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            s1    <= sw;
            s2    <= s1;
            state <= state_next;
            cnt   <= cnt_next;
            // Level follows the next state so it flips on the same edge the
            // FSM settles, rather than one cycle later.
            level <= (state_next == ONE) || (state_next == WAIT0);
            // Only a completed debounce from below pulses; WAIT0 -> ONE is a
            // rejected release and the level never left 1.
            rise  <= (state == WAIT1) && (state_next == ONE);
        end
    end

endmodule

module sw_db_pair #(
    parameter int N     = 19,
    parameter int TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_a,
    input  logic sw_b,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic b_rise
);

    logic [N-1:0] q;
    logic         m_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q + N'(1);
        end
    end

    assign m_tick = (q == {N{1'b1}});

    sw_db_chan #(.TICKS(TICKS)) u_chan_a (
        .clk    (clk),
        .reset  (reset),
        .sw     (sw_a),
        .m_tick (m_tick),
        .level  (a),
        .rise   (a_rise)
    );

    sw_db_chan #(.TICKS(TICKS)) u_chan_b (
        .clk    (clk),
        .reset  (reset),
        .sw     (sw_b),
        .m_tick (m_tick),
        .level  (b),
        .rise   (b_rise)
    );

endmodule

// File: tb/tb_sw_db_pair.sv
// Testbench for sw_db_pair with N=3 (tick every 8 clocks) and TICKS=3.
// A cycle-level reference model tracks, per channel, how long the
// synchronised input has disagreed with the debounced level and how many
// prescaler ticks have landed while it kept disagreeing.
module tb_sw_db_pair;

    localparam int N     = 3;
    localparam int TICKS = 3;
    localparam int QMAX  = (1 << N) - 1;

    logic clk = 1'b0;
    logic reset;
    logic sw_a;
    logic sw_b;
    logic a;
    logic b;
    logic a_rise;
    logic b_rise;

    always #5 clk = ~clk;

    sw_db_pair #(.N(N), .TICKS(TICKS)) dut (
        .clk    (clk),
        .reset  (reset),
        .sw_a   (sw_a),
        .sw_b   (sw_b),
        .a      (a),
        .b      (b),
        .a_rise (a_rise),
        .b_rise (b_rise)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [1:0] m_s1;
    logic [1:0] m_s2;
    logic [1:0] m_lvl;
    logic [1:0] m_rise;
    int         m_age   [2];
    int         m_ticks [2];
    int         q_m;
    logic       last_tick;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference behaviour, using pre-edge inputs.
    task automatic model_edge(input logic rst, input logic [1:0] sw);
        logic tick;
        tick = (q_m == QMAX);
        last_tick = !rst && tick;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0;
            for (int c = 0; c < 2; c++) begin
                m_age[c] = 0;
                m_ticks[c] = 0;
            end
            q_m = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                m_rise[c] = 1'b0;
                if (m_s2[c] != m_lvl[c]) begin
                    // A tick counts once the disagreement is already a cycle old.
                    if (tick && m_age[c] >= 1) m_ticks[c]++;
                    if (m_ticks[c] == TICKS) begin
                        m_lvl[c]   = ~m_lvl[c];
                        m_rise[c]  = m_lvl[c];
                        m_age[c]   = 0;
                        m_ticks[c] = 0;
                    end else begin
                        m_age[c]++;
                    end
                end else begin
                    m_age[c]   = 0;
                    m_ticks[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = sw;
            q_m  = (q_m + 1) % (QMAX + 1);
        end
    endtask

    task automatic step(input logic rst, input logic wa, input logic wb);
        reset = rst;
        sw_a  = wa;
        sw_b  = wb;
        @(posedge clk);
        model_edge(rst, {wb, wa});
        #1;
        check("model_out", {a, b, a_rise, b_rise}, {m_lvl[0], m_lvl[1], m_rise[0], m_rise[1]});
    endtask

    task automatic align_q(input int target, input logic wa, input logic wb);
        for (int i = 0; i <= QMAX && q_m != target; i++) step(1'b0, wa, wb);
    endtask

    initial begin
        int   cyc;
        int   rise_cyc;
        int   pulses;
        int   ticks;
        logic risen;
        logic seen;
        logic flag;

        reset = 1'b1;
        sw_a  = 1'b1;
        sw_b  = 1'b1;

        // Reset held 4 cycles with both switches high
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1);
            check("reset_out", {a, b, a_rise, b_rise}, 4'b0000);
        end

        // Release with switches held: rise after 2 + 1 + 3 ticks' worth
        risen = 0; pulses = 0; rise_cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (a_rise) pulses++;
            if (a && !risen) begin
                risen = 1;
                rise_cyc = i;
                check("rst_rise_coincident", {3'b000, a_rise}, 4'b0001);
            end
        end
        check_int("rst_rise_latency", rise_cyc, 24);
        check_int("rst_rise_pulses", pulses, 1);

        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);

        // Stable press aligned to q=0
        align_q(0, 1'b0, 1'b0);
        ticks = 0; risen = 0; pulses = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (last_tick) ticks++;
            if (a_rise) pulses++;
            if (b || b_rise) seen = 1;
            if (a && !risen) begin
                risen = 1;
                check_int("press_tick_count", ticks, 3);
            end
        end
        check_int("press_risen", int'(risen), 1);
        check_int("press_pulses", pulses, 1);
        check_int("press_b_quiet", int'(seen), 0);

        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);

        // Bounce rejection
        seen = 0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 3; j++) begin
                step(1'b0, (k % 2) == 0, 1'b0);
                if (a || a_rise) seen = 1;
            end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (a || a_rise) seen = 1;
        end
        check_int("bounce_rejected", int'(seen), 0);

        // Release with bounce: final drop lands on q=0
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0);
        align_q(1, 1'b1, 1'b0);
        pulses = 0; flag = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (!a) flag = 1;
            if (a_rise) pulses++;
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (!a) flag = 1;
            if (a_rise) pulses++;
        end
        check_int("release_phase", q_m, 0);
        ticks = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (last_tick) ticks++;
            if (a_rise) pulses++;
            if (!a && !seen) begin
                seen = 1;
                check_int("release_tick_count", ticks, 3);
            end
            if (!seen && !a) flag = 1;
        end
        check_int("release_held_high", int'(flag), 0);
        check_int("release_fell", int'(seen), 1);
        check_int("release_no_rise", pulses, 0);

        // Simultaneous press
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if ((a || b) && !seen) begin
                seen = 1;
                check("simul_rise", {a, b, a_rise, b_rise}, 4'b1111);
            end
        end
        check_int("simul_seen", int'(seen), 1);

        // Reset mid-debounce: A in WAIT1 with one tick counted
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);
        align_q(0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("midreset_out", {a, b, a_rise, b_rise}, 4'b0000);
        risen = 0; rise_cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (a && !risen) begin
                risen = 1;
                rise_cyc = i;
            end
        end
        check_int("midreset_restart", rise_cyc, 24);

        // Randomised traffic against the model
        begin
            logic ra;
            logic wa;
            logic wb;
            int   hold;
            wa = 1'b0; wb = 1'b0;
            for (int i = 0; i < 1500; i += hold) begin
                hold = $urandom_range(1, 30);
                if ($urandom_range(0, 1) == 1) wa = ~wa;
                if ($urandom_range(0, 1) == 1) wb = ~wb;
                ra = ($urandom_range(0, 40) == 0);
                for (int j = 0; j < hold; j++) step(ra && (j == 0), wa, wb);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sw_db_pair.md
# sw_db_pair

Two-channel switch debouncer that cleans the raw `a`/`b` switch inputs before they reach the Moore/Mealy example FSM (`fsm_eg_mult_seg`). Each channel is synchronised, then filtered by a four-state FSM driven by a shared prescaler tick. The block outputs the debounced levels, which connect to that FSM's `a`/`b`, plus a one-cycle rising-edge pulse per channel.

## Interface
Parameters:
- `N`, default 19: prescaler width. The tick period is 2^N clocks (about 10.5 ms at 50 MHz).
- `TICKS`, default 3: number of consecutive prescaler ticks the input must stay stable before the level flips. Legal range is 2..15.

Ports:
- `clk` input 1: the only clock. All registers update on the rising edge.
- `reset` input 1: synchronous, active-high. It takes effect at the next `clk` rising edge.
- `sw_a` input 1: raw, asynchronous, bouncy switch A.
- `sw_b` input 1: raw, asynchronous, bouncy switch B.
- `a` output 1: debounced level of A, registered.
- `b` output 1: debounced level of B, registered.
- `a_rise` output 1: one-cycle pulse when `a` goes 0→1, registered.
- `b_rise` output 1: one-cycle pulse when `b` goes 0→1, registered.

## Operation
Synchroniser:
- Each channel has a 2-flop synchroniser, `sw_x` → `s1` → `s2`. Only `s2` is seen by that channel's FSM.

Prescaler:
- A single N-bit free-running counter `q` is shared by both channels. It counts 0 → 2^N−1 and wraps.
- `m_tick` = (`q` == 2^N−1). It is combinational, one cycle wide, and common to both channels.

Per-channel FSM (identical and independent for A and B):
- States: ZERO, WAIT1, ONE, WAIT0.
- Each channel has a count register `cnt`, 4 bits wide.
- ZERO: if `s2`=1, go to WAIT1 and set `cnt`=0.
- WAIT1:
  - If `s2`=0, go to ZERO.
  - Else if `m_tick`: when `cnt`==TICKS−1, go to ONE; otherwise increment `cnt`.
  - If `s2`=0 and `m_tick` occur in the same cycle, `s2`=0 wins (go to ZERO).
- ONE: if `s2`=0, go to WAIT0 and set `cnt`=0.
- WAIT0:
  - If `s2`=1, go to ONE.
  - Else if `m_tick`: when `cnt`==TICKS−1, go to ZERO; otherwise increment `cnt`.
  - If `s2`=1 and `m_tick` occur in the same cycle, `s2`=1 wins (go to ONE).
- Debounced level output register: 1 when the next state is ONE or WAIT0, 0 otherwise. The output therefore changes in the same cycle the FSM enters ONE (from WAIT1) or ZERO (from WAIT0).
- Rise register: 1 for exactly one cycle, the cycle in which the level output first reads 1. It is set only on the WAIT1→ONE transition. The WAIT0→ONE return never pulses, because the level stayed 1 throughout.
- Both channels share `m_tick` but are otherwise independent. Simultaneous A and B presses produce `a`/`b` rising in the same cycle whenever both FSMs reach their final tick on the same `m_tick`. This guarantees `fsm_eg_mult_seg` sees a&b together.

## Timing
- Reset (synchronous) clears everything on the next edge: synchronisers, `q`, both `cnt`, both FSMs to ZERO, and `a`=`b`=`a_rise`=`b_rise`=0.
  - Asserting reset mid-debounce (WAIT1/WAIT0) abandons the debounce.
  - A channel held high through reset re-enters WAIT1 three cycles after reset release.
- `sw_x` edge to `s2`: 2 cycles. ZERO→WAIT1 takes 1 more cycle.
- From entering WAIT1 with the input held stable, the level rises on the edge after the TICKS-th `m_tick`.
  - The delay is between (TICKS−1)·2^N+1 and TICKS·2^N cycles, depending on the phase of `q`.
- Release (1→0) follows the same latency rule through WAIT0.
- A glitch shorter than the delay to the next `m_tick` is fully rejected. Any bounce restarts the count on the next qualifying entry into WAIT1/WAIT0.
- `a_rise` is coincident with the first cycle of `a`=1. It never asserts two cycles in a row.
- After reset release, `q` first reaches 2^N−1 at cycle 2^N−1.

## Test plan
Use N=3 (tick every 8 cycles) and TICKS=3 throughout.
- **Reset values:** hold reset 4 cycles, with `sw_a`=`sw_b`=1 throughout → `a`=`b`=`a_rise`=`b_rise`=0 throughout. After release, `a` rises within 2+1+24 cycles, with exactly one `a_rise` pulse coincident with it.
- **Stable press:** raise `sw_a` at `q`=0 and hold it → `a`=1 exactly after the 3rd subsequent `m_tick`. `a_rise` is high 1 cycle. `b` stays 0.
- **Bounce rejection:** toggle `sw_a` 1,0,1,0 every 3 cycles for 12 cycles, then hold at 0 → `a` never rises and `a_rise` never pulses.
- **Release with bounce:** with `a`=1, drop `sw_a` for 5 cycles, raise it for 2 cycles, then drop it and hold → `a` stays 1 until the 3rd `m_tick` after the final drop, then goes 0. No `a_rise` occurs at any point.
- **Simultaneous press:** raise `sw_a` and `sw_b` in the same cycle → `a`, `b`, `a_rise`, `b_rise` all assert in the same cycle.
- **Reset mid-debounce:** assert reset while A is in WAIT1 with `cnt`=1 → all outputs 0 on the next edge, and the count restarts from 0 after release.
